pipeline_hazard_ctrl: RTL and testbench

//  Sequences the IF/ID -> ID/EX -> EX pipeline: stalls, bubbles and flushes the IFID and IDEX

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/hazard_detect.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the IF/ID -> ID/EX hazard control slice: FSM state
// encodings, the NOP instruction word and the control values that form a bubble.
package pipe_ctrl_pkg;

    // Hazard FSM states; the encodings are visible on the debug state port.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } pipeState_t;

    // addi x0, x0, 0: the word IFIDBlock loads when it is flushed.
    localparam logic [31:0] NOP_INST = 32'h00000013;

    // IDEX control fields forced by a bubble (no regfile write, both Dmem strobes idle).
    typedef struct packed {
        logic regWrite;
        logic dmemReb;
        logic dmemWeb;
    } idexCtrl_t;

    localparam idexCtrl_t IDEX_BUBBLE_CTRL = idexCtrl_t'(3'b011);

endpackage

// File: rtl/hazard_detect.sv
// Pure combinational hazard detection: load-use against the EX stage and an
// outstanding (not yet ready) data-memory access.
module hazard_detect (
    input  logic       ID_valid,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic [4:0] EX_rd,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic       DmemREB,
    input  logic       DmemWEB,
    input  logic       Dmem_ready,
    output logic       loadUse,
    output logic       memBusy
);

    logic rs1Hit;
    logic rs2Hit;

    // A load writing a non-zero register that the ID instruction actually reads.
    always_comb begin
        rs1Hit  = ID_use_rs1 && (ID_rs1 == EX_rd);
        rs2Hit  = ID_use_rs2 && (ID_rs2 == EX_rd);
        loadUse = EX_MemRead && EX_RegWrite && (EX_rd != 5'd0) && ID_valid
                  && (rs1Hit || rs2Hit);
    end

    // Strobes are active-low; an access is busy until the memory signals ready.
    always_comb begin
        memBusy = (!DmemREB || !DmemWEB) && !Dmem_ready;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives hold/flush/bubble controls for the IFID and
// IDEX registers for load-use, taken branch/jump and multi-cycle Dmem hazards.
// The FSM state and counter are registered; the control outputs are decoded
// combinationally so they act in the cycle the hazard is visible.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CW           = 4
) (
    input  logic       CLK,
    input  logic       RSTB,
    input  logic       CNTEN,
    input  logic       ID_valid,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic [4:0] EX_rd,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic       PCsel,
    input  logic       DmemREB,
    input  logic       DmemWEB,
    input  logic       Dmem_ready,
    output logic       PC_stall,
    output logic       IFID_stall,
    output logic       IFID_flush,
    output logic       IDEX_bubble,
    output logic       EX_stall,
    output logic       mem_timeout,
    output logic [1:0] state
);

    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] FLUSH_LAST  = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_MAX = CW'(MEM_TIMEOUT);

    pipeState_t    stateReg;
    pipeState_t    stateNext;
    logic [CW-1:0] cntReg;
    logic [CW-1:0] cntNext;
    logic          memTimeoutReg;
    logic          setTimeout;

    logic          loadUse;
    logic          memBusy;
    logic          cntSatInc;

    logic          pcStallNext;
    logic          ifidStallNext;
    logic          ifidFlushNext;
    logic          idexBubbleNext;
    logic          exStallNext;

    hazard_detect uDetect (
        .ID_valid    (ID_valid),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_use_rs1  (ID_use_rs1),
        .ID_use_rs2  (ID_use_rs2),
        .EX_rd       (EX_rd),
        .EX_RegWrite (EX_RegWrite),
        .EX_MemRead  (EX_MemRead),
        .DmemREB     (DmemREB),
        .DmemWEB     (DmemWEB),
        .Dmem_ready  (Dmem_ready),
        .loadUse     (loadUse),
        .memBusy     (memBusy)
    );

    // Counter never wraps: it sticks at all-ones.
    assign cntSatInc = (cntReg != '1);

    // Next-state, counter and raw control decode for the running pipeline.
    always_comb begin
        stateNext      = stateReg;
        cntNext        = cntReg;
        setTimeout     = 1'b0;
        pcStallNext    = 1'b0;
        ifidStallNext  = 1'b0;
        ifidFlushNext  = 1'b0;
        idexBubbleNext = 1'b0;
        exStallNext    = 1'b0;
        case (stateReg)
            RUN, LOAD_STALL: begin
                if (memBusy) begin
                    pcStallNext   = 1'b1;
                    ifidStallNext = 1'b1;
                    exStallNext   = 1'b1;
                    stateNext     = MEM_WAIT;
                    cntNext       = CNT_ONE;
                end else if (PCsel) begin
                    // A taken branch squashes the ID instruction, so any
                    // concurrent load-use needs no stall.
                    ifidFlushNext  = 1'b1;
                    idexBubbleNext = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        stateNext = FLUSH;
                        cntNext   = CNT_ONE;
                    end else begin
                        stateNext = RUN;
                        cntNext   = '0;
                    end
                end else if (loadUse && (stateReg == RUN)) begin
                    // The single bubble is issued here; LOAD_STALL only lets
                    // the load advance so the same hazard is not re-counted.
                    pcStallNext    = 1'b1;
                    ifidStallNext  = 1'b1;
                    idexBubbleNext = 1'b1;
                    stateNext      = LOAD_STALL;
                end else begin
                    stateNext = RUN;
                end
            end
            FLUSH: begin
                if (memBusy) begin
                    // Memory stall wins; the rest of the flush window is dropped.
                    pcStallNext   = 1'b1;
                    ifidStallNext = 1'b1;
                    exStallNext   = 1'b1;
                    stateNext     = MEM_WAIT;
                    cntNext       = CNT_ONE;
                end else begin
                    ifidFlushNext  = 1'b1;
                    idexBubbleNext = 1'b1;
                    if (PCsel) begin
                        cntNext = CNT_ONE;
                    end else if (cntReg >= FLUSH_LAST) begin
                        stateNext = RUN;
                        cntNext   = '0;
                    end else if (cntSatInc) begin
                        cntNext = cntReg + CNT_ONE;
                    end
                end
            end
            MEM_WAIT: begin
                // EX is frozen here, so branch and load-use inputs are not looked at.
                if (Dmem_ready) begin
                    stateNext = RUN;
                    cntNext   = '0;
                end else begin
                    pcStallNext   = 1'b1;
                    ifidStallNext = 1'b1;
                    exStallNext   = 1'b1;
                    if (cntReg >= TIMEOUT_MAX) begin
                        setTimeout = 1'b1;
                        stateNext  = RUN;
                        cntNext    = '0;
                    end else if (cntSatInc) begin
                        cntNext = cntReg + CNT_ONE;
                    end
                end
            end
            default: begin
                stateNext = RUN;
                cntNext   = '0;
            end
        endcase
    end

    // Final outputs: quiet in reset, full freeze when the run enable is low.
    always_comb begin
        PC_stall    = 1'b0;
        IFID_stall  = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        EX_stall    = 1'b0;
        if (RSTB) begin
            if (CNTEN) begin
                PC_stall    = pcStallNext;
                IFID_stall  = ifidStallNext;
                IFID_flush  = ifidFlushNext;
                IDEX_bubble = idexBubbleNext;
                EX_stall    = exStallNext;
            end else begin
                PC_stall    = 1'b1;
                IFID_stall  = 1'b1;
                EX_stall    = 1'b1;
            end
        end
    end

    // FSM state, counter and sticky timeout flag; all hold while CNTEN is low.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            stateReg      <= RUN;
            cntReg        <= '0;
            memTimeoutReg <= 1'b0;
        end else if (CNTEN) begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (setTimeout) begin
                memTimeoutReg <= 1'b1;
            end
        end
    end

    assign mem_timeout = memTimeoutReg;
    assign state       = stateReg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each vector sets inputs, lets the
// combinational outputs settle and compares them with hand-computed values.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RSTB;
    logic       CNTEN;
    logic       ID_valid;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic       ID_use_rs1;
    logic       ID_use_rs2;
    logic [4:0] EX_rd;
    logic       EX_RegWrite;
    logic       EX_MemRead;
    logic       PCsel;
    logic       DmemREB;
    logic       DmemWEB;
    logic       Dmem_ready;
    logic       PC_stall;
    logic       IFID_stall;
    logic       IFID_flush;
    logic       IDEX_bubble;
    logic       EX_stall;
    logic       mem_timeout;
    logic [1:0] state;

    // {PC_stall, IFID_stall, IFID_flush, IDEX_bubble, EX_stall}
    logic [4:0] ctrl;
    assign ctrl = {PC_stall, IFID_stall, IFID_flush, IDEX_bubble, EX_stall};

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_LOAD  = 5'b11010;
    localparam logic [4:0] C_FLUSH = 5'b00110;
    localparam logic [4:0] C_MEM   = 5'b11001;

    int testsRun  = 0;
    int testsFail = 0;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (15),
        .CW           (4)
    ) dut (
        .CLK         (CLK),
        .RSTB        (RSTB),
        .CNTEN       (CNTEN),
        .ID_valid    (ID_valid),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_use_rs1  (ID_use_rs1),
        .ID_use_rs2  (ID_use_rs2),
        .EX_rd       (EX_rd),
        .EX_RegWrite (EX_RegWrite),
        .EX_MemRead  (EX_MemRead),
        .PCsel       (PCsel),
        .DmemREB     (DmemREB),
        .DmemWEB     (DmemWEB),
        .Dmem_ready  (Dmem_ready),
        .PC_stall    (PC_stall),
        .IFID_stall  (IFID_stall),
        .IFID_flush  (IFID_flush),
        .IDEX_bubble (IDEX_bubble),
        .EX_stall    (EX_stall),
        .mem_timeout (mem_timeout),
        .state       (state)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock and land just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        CNTEN       = 1'b1;
        ID_valid    = 1'b0;
        ID_rs1      = 5'd0;
        ID_rs2      = 5'd0;
        ID_use_rs1  = 1'b0;
        ID_use_rs2  = 1'b0;
        EX_rd       = 5'd0;
        EX_RegWrite = 1'b0;
        EX_MemRead  = 1'b0;
        PCsel       = 1'b0;
        DmemREB     = 1'b1;
        DmemWEB     = 1'b1;
        Dmem_ready  = 1'b0;
    endtask

    task automatic setLoad(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2);
        ID_valid    = 1'b1;
        EX_MemRead  = 1'b1;
        EX_RegWrite = 1'b1;
        EX_rd       = rd;
        ID_rs1      = rs1;
        ID_use_rs1  = u1;
        ID_rs2      = rs2;
        ID_use_rs2  = u2;
    endtask

    initial begin
        RSTB = 1'b0;
        idleInputs();
        #1;
        checkVal("rst_state", 32'(state), 32'd0);
        checkVal("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        checkVal("rst_timeout", 32'(mem_timeout), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RSTB = 1'b1;
        #1;
        checkVal("run_idle_ctrl", 32'(ctrl), 32'(C_NONE));

        // Load-use on rs1: one stall+bubble cycle, none in LOAD_STALL
        setLoad(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        checkVal("lu_rs1_ctrl", 32'(ctrl), 32'(C_LOAD));
        tick();
        checkVal("lu_state_ls", 32'(state), 32'd1);
        checkVal("lu_ls_ctrl", 32'(ctrl), 32'(C_NONE));
        tick();
        idleInputs();
        #1;
        checkVal("lu_back_run", 32'(state), 32'd0);
        checkVal("lu_after_ctrl", 32'(ctrl), 32'(C_NONE));

        // EX_rd = x0 never stalls
        setLoad(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        checkVal("lu_x0_ctrl", 32'(ctrl), 32'(C_NONE));
        // rs1 matches but unused; rs2 used and matches -> stall
        setLoad(5'd7, 5'd7, 1'b0, 5'd9, 1'b1);
        #1;
        checkVal("lu_rs1_unused", 32'(ctrl), 32'(C_NONE));
        ID_rs2 = 5'd7;
        #1;
        checkVal("lu_rs2_ctrl", 32'(ctrl), 32'(C_LOAD));
        ID_valid = 1'b0;
        #1;
        checkVal("lu_novalid", 32'(ctrl), 32'(C_NONE));
        idleInputs();

        // Branch: two flush cycles, state 0 -> 2 -> 0
        PCsel = 1'b1;
        #1;
        checkVal("br_c0_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        PCsel = 1'b0;
        #1;
        checkVal("br_c1_state", 32'(state), 32'd2);
        checkVal("br_c1_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        checkVal("br_end_state", 32'(state), 32'd0);
        checkVal("br_end_ctrl", 32'(ctrl), 32'(C_NONE));

        // Branch with concurrent load-use: flush only
        setLoad(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        PCsel = 1'b1;
        #1;
        checkVal("br_lu_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        idleInputs();
        #1;
        checkVal("br_lu_state", 32'(state), 32'd2);
        tick();
        checkVal("br_lu_end", 32'(state), 32'd0);

        // Dmem wait: 3 stall cycles, released on the ready cycle
        DmemREB = 1'b0;
        #1;
        checkVal("mw_c0_ctrl", 32'(ctrl), 32'(C_MEM));
        tick();
        checkVal("mw_c1_state", 32'(state), 32'd3);
        checkVal("mw_c1_ctrl", 32'(ctrl), 32'(C_MEM));
        tick();
        checkVal("mw_c2_ctrl", 32'(ctrl), 32'(C_MEM));
        Dmem_ready = 1'b1;
        #1;
        checkVal("mw_ready_ctrl", 32'(ctrl), 32'(C_NONE));
        tick();
        idleInputs();
        #1;
        checkVal("mw_end_state", 32'(state), 32'd0);
        checkVal("mw_timeout", 32'(mem_timeout), 32'd0);

        // Flush preempted by a Dmem access
        PCsel = 1'b1;
        tick();
        PCsel   = 1'b0;
        DmemWEB = 1'b0;
        #1;
        checkVal("pre_ctrl", 32'(ctrl), 32'(C_MEM));
        tick();
        checkVal("pre_state", 32'(state), 32'd3);
        Dmem_ready = 1'b1;
        tick();
        idleInputs();
        #1;
        checkVal("pre_end_state", 32'(state), 32'd0);

        // CNTEN=0 mid-flush freezes the FSM and forces stalls, no flush
        PCsel = 1'b1;
        tick();
        PCsel = 1'b0;
        CNTEN = 1'b0;
        #1;
        checkVal("frz_ctrl", 32'(ctrl), 32'(C_MEM));
        tick();
        tick();
        checkVal("frz_state", 32'(state), 32'd2);
        CNTEN = 1'b1;
        #1;
        checkVal("frz_resume_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        checkVal("frz_end_state", 32'(state), 32'd0);

        // Timeout: ready never arrives; flag rises once cnt hits 15
        DmemREB = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checkVal("to_c15_state", 32'(state), 32'd3);
        checkVal("to_c15_flag", 32'(mem_timeout), 32'd0);
        tick();
        checkVal("to_state", 32'(state), 32'd0);
        checkVal("to_flag", 32'(mem_timeout), 32'd1);
        DmemREB = 1'b1;
        tick();
        tick();
        checkVal("to_sticky", 32'(mem_timeout), 32'd1);
        checkVal("to_idle_ctrl", 32'(ctrl), 32'(C_NONE));

        // Async reset in the middle of MEM_WAIT
        DmemREB = 1'b0;
        tick();
        tick();
        checkVal("ar_pre_state", 32'(state), 32'd3);
        RSTB = 1'b0;
        #1;
        checkVal("ar_state", 32'(state), 32'd0);
        checkVal("ar_ctrl", 32'(ctrl), 32'(C_NONE));
        checkVal("ar_timeout", 32'(mem_timeout), 32'd0);
        idleInputs();
        tick();
        RSTB = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
